// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack bus and buffers up to two
// (pc, inst) pairs for the IF/ID register, flushing on EX redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Hazard,
  input  logic                Redirect,
  input  logic [31:0]         RedirectPC,
  inst_fetch_if.master        imem,
  output logic [31:0]         PCOut,
  output logic [31:0]         InstOut,
  output logic                IF_IDFlash
);

  typedef enum logic [1:0] {StIdle, StBusy, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q [2];
  logic [31:0] inst_q [2];
  logic [31:0] pc_d [2];
  logic [31:0] inst_d [2];

  logic       accept;
  logic       pop;
  logic       push;
  logic [1:0] next_count;

  assign accept     = req_q & imem.imem_ack;
  assign pop        = (count_q != 2'd0) & ~Hazard & ~Redirect;
  assign push       = (state_q == StBusy) & accept & ~Redirect;
  assign next_count = count_q - {1'b0, pop} + {1'b0, push};

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= 2'd0;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= 32'h0;
        inst_q[i] <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= pc_d[i];
        inst_q[i] <= inst_d[i];
      end
    end
  end

  // Head lives in slot 0; after an optional shift the new entry lands at next_count-1.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    count_d = Redirect ? 2'd0 : next_count;
    if (pop) begin
      pc_d[0]   = pc_q[1];
      inst_d[0] = inst_q[1];
    end
    if (push) begin
      pc_d[next_count[1]]   = addr_q;
      inst_d[next_count[1]] = imem.imem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    case (state_q)
      StIdle: begin
        if (Redirect) begin
          fetch_pc_d = RedirectPC;
        end else if (next_count < 2'd2) begin
          state_d = StBusy;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      StBusy: begin
        if (accept && Redirect) begin
          addr_d     = RedirectPC;
          fetch_pc_d = RedirectPC;
        end else if (accept) begin
          fetch_pc_d = addr_q + 32'd4;
          if (next_count < 2'd2) begin
            addr_d = addr_q + 32'd4;
          end else begin
            state_d = StIdle;
            req_d   = 1'b0;
          end
        end else if (Redirect) begin
          // The outstanding request cannot be withdrawn; its data is dropped later.
          state_d    = StDiscard;
          fetch_pc_d = RedirectPC;
        end
      end
      StDiscard: begin
        if (accept) begin
          state_d    = StBusy;
          addr_d     = Redirect ? RedirectPC : fetch_pc_q;
          fetch_pc_d = Redirect ? RedirectPC : fetch_pc_q;
        end else if (Redirect) begin
          fetch_pc_d = RedirectPC;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    PCOut      = (count_q != 2'd0) ? pc_q[0] : 32'h0;
    InstOut    = (count_q != 2'd0) ? inst_q[0] : 32'h0;
    IF_IDFlash = Redirect | (count_q == 2'd0);
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the producer side of the IF/ID pipeline register. It owns the program counter, runs a request/acknowledge handshake to instruction memory, and buffers up to two fetched (PC, instruction) pairs. It presents the oldest pair on PCOut/InstOut and drives IF_IDFlash to insert a NOP whenever no valid instruction is available or a redirect occurs. It honours the same Hazard stall that freezes the IF/ID register and accepts branch/jump redirects from EX.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- Hazard  input  1  stall from the hazard unit; the IF/ID register holds while it is 1
- Redirect  input  1  taken branch/jump from EX; flushes fetched state
- RedirectPC  input  32  new fetch address, valid while Redirect=1
- imem_req  output  1  memory request, registered
- imem_addr  output  32  request address, registered, stable while imem_req=1
- imem_ack  input  1  memory completion; imem_rdata is valid in the same cycle
- imem_rdata  input  32  fetched instruction word
- PCOut  output  32  head-entry PC, feeds IF/ID PCIn
- InstOut  output  32  head-entry instruction, feeds IF/ID InstIn
- IF_IDFlash  output  1  forces IF/ID to load zeros (NOP)

## Operation
- **Buffer.** 2-entry FIFO of {pc, inst} plus a 2-bit count (0..2).
  - When count=0, PCOut/InstOut are 0.
  - Otherwise PCOut/InstOut show the head entry, combinationally.
- **IF_IDFlash** = Redirect | (count==0).
- **Pop** = (count!=0) & ~Hazard & ~Redirect. This matches the IF/ID capture rule: the register loads on any edge with Hazard=0.
- **Accepted response** = imem_req & imem_ack.
- **FSM states:**
  - IDLE: no request outstanding.
  - BUSY: request outstanding; its result is kept.
  - DISCARD: request outstanding; its result is dropped.
- **next_count** = count − pop + push.
- **IDLE:**
  - If next_count<2 and no Redirect: go to BUSY, imem_req<=1, imem_addr<=fetch_pc.
  - On Redirect: fetch_pc<=RedirectPC, then issue at RedirectPC on the next decision.
- **BUSY, ack without Redirect:**
  - push {imem_addr, imem_rdata}; fetch_pc<=imem_addr+4.
  - If next_count<2: stay BUSY with imem_addr<=imem_addr+4 (back-to-back fetch).
  - Else: go to IDLE, imem_req<=0.
- **BUSY, no ack, Redirect:** go to DISCARD; fetch_pc<=RedirectPC. imem_req and imem_addr stay unchanged; a pending request is never withdrawn.
- **BUSY, ack and Redirect in the same cycle:** drop the data; stay BUSY with imem_addr<=RedirectPC; fetch_pc<=RedirectPC.
- **DISCARD:**
  - On ack: drop the data; go to BUSY with imem_addr<=fetch_pc.
  - On Redirect: fetch_pc<=RedirectPC.
  - On both in the same cycle: imem_addr<=RedirectPC.
- **Any Redirect** sets count<=0 that edge; a push in the same cycle is suppressed.
- **Arithmetic:** PC increments by 4 modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Addresses are not checked for alignment.
- **Hazard and Redirect together:** the buffer is still flushed and IF_IDFlash=1. IF/ID holds per its own rule, so no instruction is lost or duplicated.

## Timing
- **Reset** (rst_n=0 at an edge) sets:
  - state=IDLE, count=0, fetch_pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - PCOut=0, InstOut=0, IF_IDFlash=1
- **Reset mid-request:** an outstanding request is abandoned and a late imem_ack is ignored. The memory must itself be reset in the same cycle.
- **First edge with rst_n=1:** IDLE issues, so imem_req=1 and imem_addr=RESET_PC after that edge.
- **Fetch latency:** the edge sampling the ack writes the buffer. PCOut/InstOut/IF_IDFlash=0 are valid immediately after that edge, and IF/ID captures on the following edge if Hazard=0.
- **Throughput:** one instruction per cycle when memory acks every cycle and Hazard=0. The buffer never overflows because a request is only issued or continued when next_count<2.

## Test plan
- **Reset, single-cycle memory** (RESET_PC=0x100, ack each cycle, Hazard=0) -> imem_addr sequence 0x100, 0x104, 0x108…; PCOut sequence 0x100, 0x104… one per cycle; IF_IDFlash=1 only before the first fill.
- **Hazard=1 for 3 cycles mid-stream** -> PCOut is held; buffer fills to 2 and imem_req drops; after release, the PC stream continues with no gaps or duplicates.
- **Redirect to 0x2000 while BUSY without ack, ack arrives 2 cycles later** -> that data is dropped and IF_IDFlash=1; the next request is at 0x2000 and the first PCOut is 0x2000.
- **Redirect to 0x40 in the same cycle as ack of 0x10C** -> 0x10C never appears on PCOut; imem_addr=0x40 the next cycle.
- **Wrap-around** (RESET_PC=0xFFFF_FFF8) -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **rst_n=0 for one cycle while BUSY with count=2** -> all outputs return to their reset values; fetch restarts at RESET_PC.
